// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Operand/result sequencer around an external 8-bit add/subtract ALU.
// Commands (LOAD_A, LOAD_B, ADD, SUB) arrive over a valid/ready handshake.
// The block holds the A/B operand registers and the subtract select that
// drive the ALU. It captures the ALU result one cycle after an ADD/SUB is
// launched. The captured result and its carry/zero flags go to a consumer
// over a second valid/ready handshake. With ACC_WRITEBACK=1 every ADD/SUB
// result is also written back into A, so A behaves as an accumulator.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op[1:0]           00 LOAD_A, 01 LOAD_B, 10 ADD, 11 SUB
//   cmd_data[7:0]         operand for LOADs (ignored for ADD/SUB)
//   alu_a, alu_b          operand registers, to the ALU
//   alu_sub               ALU subtract select
//   alu_out, alu_carry    ALU result and carry-out
//   res_valid/res_ready   result handshake
//   res_data, res_carry   captured ALU result and carry
//   res_zero              captured result equals zero
//   op_count              number of completed result handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter bit ACC_WRITEBACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_sub,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_zero,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXEC   = 2'b01,
        ST_RESULT = 2'b10
    } state_t;

    localparam logic [1:0] OP_LOAD_A = 2'b00;
    localparam logic [1:0] OP_LOAD_B = 2'b01;

    state_t     state_reg;
    logic       cmd_ready_reg;
    logic       res_valid_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       sub_reg;
    logic [7:0] res_data_reg;
    logic       res_carry_reg;
    logic       res_zero_reg;
    logic [7:0] op_count_reg;

    // Handshake outputs are registered alongside the state so that no
    // command or res_ready input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b1;
            res_valid_reg <= 1'b0;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            sub_reg       <= 1'b0;
            res_data_reg  <= 8'h00;
            res_carry_reg <= 1'b0;
            res_zero_reg  <= 1'b0;
            op_count_reg  <= 8'h00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD_A: a_reg <= cmd_data;
                            OP_LOAD_B: b_reg <= cmd_data;
                            default: begin
                                // ADD/SUB: operands already sit in A/B, only
                                // the subtract select changes at launch.
                                sub_reg       <= cmd_op[0];
                                state_reg     <= ST_EXEC;
                                cmd_ready_reg <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    // ALU inputs have been stable since launch; take the result.
                    res_data_reg  <= alu_out;
                    res_carry_reg <= alu_carry;
                    res_zero_reg  <= (alu_out == 8'h00);
                    if (ACC_WRITEBACK) begin
                        a_reg <= alu_out;
                    end
                    state_reg     <= ST_RESULT;
                    res_valid_reg <= 1'b1;
                end
                ST_RESULT: begin
                    // Result registers are untouched here, so they stay
                    // stable for as long as the consumer stalls.
                    if (res_ready) begin
                        state_reg     <= ST_IDLE;
                        res_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        op_count_reg  <= op_count_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    res_valid_reg <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign res_valid = res_valid_reg;
    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign alu_sub   = sub_reg;
    assign res_data  = res_data_reg;
    assign res_carry = res_carry_reg;
    assign res_zero  = res_zero_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Two sequencer instances share one stimulus stream: dut_acc has
// ACC_WRITEBACK=1 and dut_noacc has ACC_WRITEBACK=0. Each instance drives its
// own behavioural ALU. Expected results are computed from the bench's own
// operand model and pushed to a scoreboard queue when an ADD/SUB is issued.
// They are popped and compared when the result handshake happens.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       z;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       res_ready;

    logic       cmd_ready1, alu_sub1, alu_carry1, res_valid1, res_carry1, res_zero1;
    logic [7:0] alu_a1, alu_b1, alu_out1, res_data1, op_count1;
    logic       cmd_ready0, alu_sub0, alu_carry0, res_valid0, res_carry0, res_zero0;
    logic [7:0] alu_a0, alu_b0, alu_out0, res_data0, op_count0;

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU: subtraction as A + ~B + 1, carry-out taken
    // straight from the 9-bit adder.
    logic [8:0] alu_sum1, alu_sum0;
    assign alu_sum1   = alu_sub1 ? ({1'b0, alu_a1} + {1'b0, ~alu_b1} + 9'd1)
                                 : ({1'b0, alu_a1} + {1'b0, alu_b1});
    assign alu_out1   = alu_sum1[7:0];
    assign alu_carry1 = alu_sum1[8];
    assign alu_sum0   = alu_sub0 ? ({1'b0, alu_a0} + {1'b0, ~alu_b0} + 9'd1)
                                 : ({1'b0, alu_a0} + {1'b0, alu_b0});
    assign alu_out0   = alu_sum0[7:0];
    assign alu_carry0 = alu_sum0[8];

    alu_op_sequencer #(.ACC_WRITEBACK(1'b1)) dut_acc (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sub(alu_sub1),
        .alu_out(alu_out1), .alu_carry(alu_carry1),
        .res_valid(res_valid1), .res_ready(res_ready),
        .res_data(res_data1), .res_carry(res_carry1), .res_zero(res_zero1),
        .op_count(op_count1)
    );

    alu_op_sequencer #(.ACC_WRITEBACK(1'b0)) dut_noacc (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_sub(alu_sub0),
        .alu_out(alu_out0), .alu_carry(alu_carry0),
        .res_valid(res_valid0), .res_ready(res_ready),
        .res_data(res_data0), .res_carry(res_carry0), .res_zero(res_zero0),
        .op_count(op_count0)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Bench-side model of operand registers and handshake count.
    logic [7:0] ma1, mb1, ma0, mb0, mcnt;
    res_t sb1[$];
    res_t sb0[$];
    res_t obs1, obs0;

    function automatic res_t expect_res(input logic [7:0] a, input logic [7:0] b, input logic sub);
        res_t r;
        logic [7:0] d;
        logic c;
        if (sub) begin
            d = a - b;
            c = (a >= b);
        end else begin
            {c, d} = {1'b0, a} + {1'b0, b};
        end
        r.d = d;
        r.c = c;
        r.z = (d == 8'h00);
        return r;
    endfunction

    task automatic model_reset();
        ma1 = 8'h00; mb1 = 8'h00; ma0 = 8'h00; mb0 = 8'h00; mcnt = 8'h00;
        sb1.delete();
        sb0.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        n_vec++;
        if (cmd_ready1 !== 1'b1 || cmd_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: got %b/%b want 1/1", cmd_ready1, cmd_ready0);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'b00) begin ma1 = d; ma0 = d; end
        else begin mb1 = d; mb0 = d; end
        n_vec++;
        if (alu_a1 !== ma1 || alu_b1 !== mb1 || alu_a0 !== ma0 || alu_b0 !== mb0) begin
            n_fail++;
            $display("FAIL load_regs: got a=%h b=%h / a=%h b=%h want a=%h b=%h / a=%h b=%h",
                     alu_a1, alu_b1, alu_a0, alu_b0, ma1, mb1, ma0, mb0);
        end
        $display("load op=%0d data=%h", op, d);
    endtask

    // Issue ADD (sub=0) or SUB (sub=1). When 'driven' is set the command is
    // already on the bus and will be accepted at the coming edge.
    task automatic issue(input logic sub, input bit driven);
        res_t e1, e0;
        if (!driven) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = {1'b1, sub};
            cmd_data  = 8'($urandom);
        end
        e1 = expect_res(ma1, mb1, sub);
        e0 = expect_res(ma0, mb0, sub);
        sb1.push_back(e1);
        sb0.push_back(e0);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_vec++;
        if (cmd_ready1 !== 1'b0 || res_valid1 !== 1'b0 || cmd_ready0 !== 1'b0 || res_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_state: got rdy=%b/%b vld=%b/%b want 0/0 0/0",
                     cmd_ready1, cmd_ready0, res_valid1, res_valid0);
        end
        n_vec++;
        if (alu_sub1 !== sub || alu_sub0 !== sub) begin
            n_fail++;
            $display("FAIL alu_sub: got %b/%b want %b", alu_sub1, alu_sub0, sub);
        end
        @(negedge clk);
        n_vec++;
        if (res_valid1 !== 1'b1 || res_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL res_valid_latency: got %b/%b want 1/1", res_valid1, res_valid0);
        end
        ma1 = e1.d;
        n_vec++;
        if (alu_a1 !== ma1 || alu_a0 !== ma0 || alu_b1 !== mb1 || alu_b0 !== mb0) begin
            n_fail++;
            $display("FAIL writeback: got a=%h/%h b=%h/%h want a=%h/%h b=%h/%h",
                     alu_a1, alu_a0, alu_b1, alu_b0, ma1, ma0, mb1, mb0);
        end
    endtask

    // Stall the consumer for 'hold' cycles, then complete one result handshake.
    task automatic drain(input int hold);
        res_t s1, s0, got1, got0, e1, e0;
        int n;
        s1 = {res_data1, res_carry1, res_zero1};
        s0 = {res_data0, res_carry0, res_zero0};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if ({res_data1, res_carry1, res_zero1} !== s1 || {res_data0, res_carry0, res_zero0} !== s0 ||
                res_valid1 !== 1'b1 || res_valid0 !== 1'b1 || cmd_ready1 !== 1'b0 || cmd_ready0 !== 1'b0 ||
                alu_a1 !== ma1 || alu_a0 !== ma0) begin
                n_fail++;
                $display("FAIL hold_stable: got res=%h/%h vld=%b/%b rdy=%b/%b a=%h/%h want res=%h/%h vld=1 rdy=0 a=%h/%h",
                         {res_data1, res_carry1, res_zero1}, {res_data0, res_carry0, res_zero0},
                         res_valid1, res_valid0, cmd_ready1, cmd_ready0, alu_a1, alu_a0, s1, s0, ma1, ma0);
            end
        end
        res_ready = 1'b1;
        n = 0;
        while (res_valid1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL res_valid_timeout: got res_valid=%b want 1 within 20 cycles", res_valid1);
        end
        got1 = {res_data1, res_carry1, res_zero1};
        got0 = {res_data0, res_carry0, res_zero0};
        n_vec++;
        if (sb1.size() == 0 || sb0.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d/%0d entries want >=1", sb1.size(), sb0.size());
        end else begin
            e1 = sb1.pop_front();
            e0 = sb0.pop_front();
            if (got1 !== e1) begin
                n_fail++;
                $display("FAIL result_acc: got d=%h c=%b z=%b want d=%h c=%b z=%b",
                         got1.d, got1.c, got1.z, e1.d, e1.c, e1.z);
            end
            n_vec++;
            if (got0 !== e0) begin
                n_fail++;
                $display("FAIL result_noacc: got d=%h c=%b z=%b want d=%h c=%b z=%b",
                         got0.d, got0.c, got0.z, e0.d, e0.c, e0.z);
            end
        end
        obs1 = got1;
        obs0 = got0;
        @(negedge clk);
        res_ready = 1'b0;
        mcnt = mcnt + 8'd1;
        n_vec++;
        if (op_count1 !== mcnt || op_count0 !== mcnt || res_valid1 !== 1'b0 || cmd_ready1 !== 1'b1 ||
            res_valid0 !== 1'b0 || cmd_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: got cnt=%h/%h vld=%b/%b rdy=%b/%b want cnt=%h vld=0 rdy=1",
                     op_count1, op_count0, res_valid1, res_valid0, cmd_ready1, cmd_ready0, mcnt);
        end
        $display("result #%0d: acc d=%h c=%b z=%b | noacc d=%h c=%b z=%b",
                 mcnt, got1.d, got1.c, got1.z, got0.d, got0.c, got0.z);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; res_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (cmd_ready1 !== 1'b1 || res_valid1 !== 1'b0 || alu_a1 !== 8'h00 || alu_b1 !== 8'h00 ||
            alu_sub1 !== 1'b0 || res_data1 !== 8'h00 || res_carry1 !== 1'b0 || res_zero1 !== 1'b0 ||
            op_count1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b a=%h b=%h sub=%b d=%h c=%b z=%b cnt=%h want 1 0 00 00 0 00 0 0 00",
                     cmd_ready1, res_valid1, alu_a1, alu_b1, alu_sub1, res_data1, res_carry1, res_zero1, op_count1);
        end
        rst_n = 1'b1;
        // Complete one op, then reset while the next result is pending.
        load(2'b00, 8'h11);
        load(2'b01, 8'h22);
        issue(1'b0, 1'b0);
        drain(0);
        issue(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (res_valid1 !== 1'b0 || res_valid0 !== 1'b0 || cmd_ready1 !== 1'b1 || op_count1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_result: got vld=%b/%b rdy=%b cnt=%h want vld=0/0 rdy=1 cnt=00",
                     res_valid1, res_valid0, cmd_ready1, op_count1);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready1 !== 1'b1 || alu_a1 !== 8'h00 || alu_b1 !== 8'h00 || op_count1 !== 8'h00 ||
            res_valid1 !== 1'b0 || res_data1 !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset: got rdy=%b a=%h b=%h cnt=%h vld=%b d=%h want 1 00 00 00 0 00",
                     cmd_ready1, alu_a1, alu_b1, op_count1, res_valid1, res_data1);
        end
    endtask

    task automatic test_add_carry();
        load(2'b00, 8'hC8);
        load(2'b01, 8'h64);
        issue(1'b0, 1'b0);
        drain(0);
        n_vec++;
        if (obs1.d !== 8'h2C || obs1.c !== 1'b1 || obs1.z !== 1'b0 || op_count1 !== 8'h01) begin
            n_fail++;
            $display("FAIL add_carry: got d=%h c=%b z=%b cnt=%h want 2c 1 0 01", obs1.d, obs1.c, obs1.z, op_count1);
        end
    endtask

    task automatic test_sub_borrow();
        load(2'b00, 8'h05);
        load(2'b01, 8'h07);
        issue(1'b1, 1'b0);
        drain(2);
        n_vec++;
        if (obs1.d !== 8'hFE || obs1.c !== 1'b0 || alu_a1 !== 8'hFE || alu_a0 !== 8'h05) begin
            n_fail++;
            $display("FAIL sub_borrow: got d=%h c=%b a=%h/%h want fe 0 a=fe/05", obs1.d, obs1.c, alu_a1, alu_a0);
        end
    endtask

    task automatic test_zero();
        load(2'b00, 8'h07);
        load(2'b01, 8'h07);
        issue(1'b1, 1'b0);
        drain(1);
        n_vec++;
        if (obs1.d !== 8'h00 || obs1.z !== 1'b1 || obs1.c !== 1'b1 || obs0.z !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_result: got d=%h z=%b c=%b z0=%b want 00 1 1 1", obs1.d, obs1.z, obs1.c, obs0.z);
        end
    endtask

    task automatic test_backpressure();
        load(2'b00, 8'h10);
        load(2'b01, 8'h20);
        issue(1'b0, 1'b0);
        // Present the next ADD while the consumer stalls; it must wait.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 8'h5A;
        drain(5);
        issue(1'b0, 1'b1);
        drain(0);
        n_vec++;
        if (obs1.d !== 8'h50 || obs0.d !== 8'h30) begin
            n_fail++;
            $display("FAIL backpressure_second: got %h/%h want 50/30", obs1.d, obs0.d);
        end
    endtask

    task automatic test_back_to_back_accumulate();
        pulse_reset();
        load(2'b00, 8'h00);
        load(2'b01, 8'h01);
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, 1'b0);
            drain(0);
            n_vec++;
            if (obs0.d !== 8'h01) begin
                n_fail++;
                $display("FAIL noacc_const: got %h want 01 at op %0d", obs0.d, i);
            end
        end
        n_vec++;
        if (obs1.d !== 8'h00 || obs1.c !== 1'b1 || op_count1 !== 8'h00 || op_count0 !== 8'h00) begin
            n_fail++;
            $display("FAIL accumulate_wrap: got d=%h c=%b cnt=%h/%h want 00 1 00/00",
                     obs1.d, obs1.c, op_count1, op_count0);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_zero();
        test_backpressure();
        test_back_to_back_accumulate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
